// File: rtl/nabp_shift_sequencer_if.sv
// Fill/shift handshake between nabp_shift_sequencer (master) and the shifter (slave).
interface nabp_shift_sequencer_if #(
    parameter int unsigned ACCU_WIDTH = 16
);
    logic                  sc_fill_kick;
    logic                  sc_shift_kick;
    logic [ACCU_WIDTH-1:0] sc_accu_base;
    logic                  sc_fill_done;
    logic                  sc_shift_done;

    modport master (
        output sc_fill_kick,
        output sc_shift_kick,
        output sc_accu_base,
        input  sc_fill_done,
        input  sc_shift_done
    );

    modport slave (
        input  sc_fill_kick,
        input  sc_shift_kick,
        input  sc_accu_base,
        output sc_fill_done,
        output sc_shift_done
    );
endinterface

// File: rtl/nabp_shift_sequencer.sv
// Per-projection fill/shift sequencer: walks angles, latches ROM accu base, kicks the shifter.
// Optional watchdog on the fill/shift wait states: define NABP_SHIFT_SEQ_WATCHDOG_EN.
module nabp_shift_sequencer #(
    parameter int unsigned NUM_ANGLES  = 180,
    parameter int unsigned ANGLE_WIDTH = 8,
    parameter int unsigned ACCU_WIDTH  = 16,
    parameter int unsigned WDOG_CYCLES = 4095
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ANGLE_WIDTH-1:0] angle,
    output logic [ANGLE_WIDTH-1:0] rom_addr,
    input  logic [ACCU_WIDTH-1:0]  rom_data,
    input  logic                   pe_ready,
    nabp_shift_sequencer_if.master sc
);

    localparam logic [ANGLE_WIDTH-1:0] LAST_ANGLE = ANGLE_WIDTH'(NUM_ANGLES - 1);

    if (NUM_ANGLES < 32'd1 || 64'(NUM_ANGLES) > (64'd1 << ANGLE_WIDTH) || WDOG_CYCLES < 32'd1)
    begin : g_cfg_err
        $error("nabp_shift_sequencer: illegal parameter combination");
    end

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_LOAD       = 4'd1,
        ST_LATCH      = 4'd2,
        ST_FILL_KICK  = 4'd3,
        ST_FILL_WAIT  = 4'd4,
        ST_PE_WAIT    = 4'd5,
        ST_SHIFT_KICK = 4'd6,
        ST_SHIFT_WAIT = 4'd7,
        ST_NEXT       = 4'd8
    } state_e;

    state_e                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    fill_kick_q, fill_kick_d;
    logic                    shift_kick_q, shift_kick_d;
    logic [ANGLE_WIDTH-1:0]  angle_q, angle_d;
    logic [ANGLE_WIDTH-1:0]  rom_addr_q, rom_addr_d;
    logic [ACCU_WIDTH-1:0]   accu_base_q, accu_base_d;
    logic                    wdog_expired;
    logic                    last_angle;

    assign last_angle = (angle_q == LAST_ANGLE);

`ifdef NABP_SHIFT_SEQ_WATCHDOG_EN
    localparam int unsigned       WDOG_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;

    // Counter restarts on each kick, so it measures time spent in the wait state that follows.
    always_comb begin
        wdog_d       = wdog_q;
        wdog_expired = 1'b0;
        if (state_q == ST_FILL_KICK || state_q == ST_SHIFT_KICK) begin
            wdog_d = '0;
        end else if (state_q == ST_FILL_WAIT || state_q == ST_SHIFT_WAIT) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
        if ((state_q == ST_FILL_WAIT  && !sc.sc_fill_done) ||
            (state_q == ST_SHIFT_WAIT && !sc.sc_shift_done)) begin
            wdog_expired = (wdog_q == WDOG_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_expired = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition, including start.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:       if (start) state_d = ST_LOAD;
            ST_LOAD:       state_d = ST_LATCH;
            ST_LATCH:      state_d = ST_FILL_KICK;
            ST_FILL_KICK:  state_d = ST_FILL_WAIT;
            ST_FILL_WAIT: begin
                if (sc.sc_fill_done)    state_d = ST_PE_WAIT;
                else if (wdog_expired)  state_d = ST_IDLE;
            end
            ST_PE_WAIT:    if (pe_ready) state_d = ST_SHIFT_KICK;
            ST_SHIFT_KICK: state_d = ST_SHIFT_WAIT;
            ST_SHIFT_WAIT: begin
                if (sc.sc_shift_done)   state_d = ST_NEXT;
                else if (wdog_expired)  state_d = ST_IDLE;
            end
            ST_NEXT:       state_d = last_angle ? ST_IDLE : ST_LOAD;
            default:       state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // Output logic: registered outputs are computed from the state being entered.
    always_comb begin
        busy_d       = (state_d != ST_IDLE);
        fill_kick_d  = (state_d == ST_FILL_KICK);
        shift_kick_d = (state_d == ST_SHIFT_KICK);
        done_d       = 1'b0;
        angle_d      = angle_q;
        rom_addr_d   = rom_addr_q;
        accu_base_d  = accu_base_q;
        error_d      = error_q;

        if (!abort) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        angle_d = '0;
                        error_d = 1'b0;
                    end
                end
                ST_LATCH: accu_base_d = rom_data;
                ST_NEXT: begin
                    if (last_angle) done_d  = 1'b1;
                    else            angle_d = angle_q + ANGLE_WIDTH'(1);
                end
                default: ;
            endcase
            if (wdog_expired) begin
                error_d = 1'b1;
            end
        end

        if (state_d == ST_LOAD) begin
            rom_addr_d = angle_d;
        end

`ifndef NABP_SHIFT_SEQ_WATCHDOG_EN
        error_d = 1'b0;
`endif
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            fill_kick_q  <= 1'b0;
            shift_kick_q <= 1'b0;
            angle_q      <= '0;
            rom_addr_q   <= '0;
            accu_base_q  <= '0;
        end else begin
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            fill_kick_q  <= fill_kick_d;
            shift_kick_q <= shift_kick_d;
            angle_q      <= angle_d;
            rom_addr_q   <= rom_addr_d;
            accu_base_q  <= accu_base_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign angle            = angle_q;
    assign rom_addr         = rom_addr_q;
    assign sc.sc_fill_kick  = fill_kick_q;
    assign sc.sc_shift_kick = shift_kick_q;
    assign sc.sc_accu_base  = accu_base_q;

endmodule
